// File: rtl/mem_wb_if.sv
// mem_wb_if: handshake and payload bundle between the MEM stage, the
// MEM/WB elastic register and the WB stage.
//
// Handshake: an entry moves across a side in a cycle exactly when that
// side's valid and ready are both 1 at the rising clock edge. Once valid is
// raised, the source holds valid and the payload stable until the transfer.
//
// Modports:
//   slave  - the pipeline register. It receives in_* / mem_* / out_ready and
//            drives in_ready, out_valid and wb_*.
//   master - the environment (MEM and WB stages), with the opposite
//            directions.
interface mem_wb_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     mem_reg_write;
  logic                     mem_mem_read;
  logic [DATA_WIDTH-1:0]    mem_read_data;
  logic [DATA_WIDTH-1:0]    mem_alu_result;
  logic [REGADDR_WIDTH-1:0] mem_rd;
  logic                     out_valid;
  logic                     out_ready;
  logic                     wb_reg_write;
  logic                     wb_mem_to_reg;
  logic [DATA_WIDTH-1:0]    wb_read_data;
  logic [DATA_WIDTH-1:0]    wb_alu_result;
  logic [REGADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]    wb_write_data;
  logic                     wb_rf_we;

  modport slave (
    input  in_valid, mem_reg_write, mem_mem_read, mem_read_data,
           mem_alu_result, mem_rd, out_ready,
    output in_ready, out_valid, wb_reg_write, wb_mem_to_reg, wb_read_data,
           wb_alu_result, wb_rd, wb_write_data, wb_rf_we
  );

  modport master (
    output in_valid, mem_reg_write, mem_mem_read, mem_read_data,
           mem_alu_result, mem_rd, out_ready,
    input  in_ready, out_valid, wb_reg_write, wb_mem_to_reg, wb_read_data,
           wb_alu_result, wb_rd, wb_write_data, wb_rf_we
  );
endinterface

// File: rtl/mem_wb_elastic.sv
// mem_wb_elastic: MEM/WB pipeline register with a 2-entry skid buffer.
// WB can stall MEM without a combinational ready path: in_ready is a flop
// that reflects "not FULL" for the next cycle. Entries leave strictly in
// arrival order. Also forms the writeback mux and a one-cycle RF write enable.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous reset, active low
//   flush     - drop every held entry (and any entry offered this cycle)
//   bus       - mem_wb_if.slave: in_valid/in_ready + mem_* payload in,
//               out_valid/out_ready + wb_* head payload out
//   dbg_state - current occupancy state (0 EMPTY, 1 ONE, 2 FULL)
//   stat_retired, stat_stall - pop / stall counters, present only when the
//               macro MEM_WB_STATS_EN is defined
module mem_wb_elastic #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3,
  parameter int STAT_WIDTH    = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  mem_wb_if.slave        bus,
  output logic [1:0]     dbg_state
`ifdef MEM_WB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_retired,
  output logic [STAT_WIDTH-1:0] stat_stall
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic                     reg_write;
    logic                     mem_read;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [REGADDR_WIDTH-1:0] rd;
  } entry_t;

  state_t state, next_state;
  entry_t main_q, skid_q, in_entry;
  logic   in_ready_q;
  logic   accept, pop;
  logic   load_main_in, load_skid_in, move_skid;

  assign in_entry = '{reg_write:  bus.mem_reg_write,
                      mem_read:   bus.mem_mem_read,
                      read_data:  bus.mem_read_data,
                      alu_result: bus.mem_alu_result,
                      rd:         bus.mem_rd};

  // Main is valid in ONE and FULL; skid is valid only in FULL.
  assign bus.out_valid = (state != EMPTY);
  assign bus.in_ready  = in_ready_q;
  assign accept        = bus.in_valid & in_ready_q;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    next_state   = state;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          next_state   = FULL;
          load_skid_in = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        // in_ready is 0 here, so only a pop can happen.
        if (pop) begin
          next_state = ONE;
          move_skid  = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush squashes everything, including an entry accepted this cycle.
    if (flush) begin
      next_state   = EMPTY;
      load_main_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != FULL);
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.wb_reg_write  = main_q.reg_write;
  assign bus.wb_mem_to_reg = main_q.mem_read;
  assign bus.wb_read_data  = main_q.read_data;
  assign bus.wb_alu_result = main_q.alu_result;
  assign bus.wb_rd         = main_q.rd;
  assign bus.wb_write_data = main_q.mem_read ? main_q.read_data : main_q.alu_result;
  // Gated by out_valid so a stale reg_write in an empty main never writes.
  assign bus.wb_rf_we      = pop & main_q.reg_write;
  assign dbg_state         = state;

`ifdef MEM_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_retired <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop) begin
        stat_retired <= stat_retired + 1'b1;
      end
      if (bus.out_valid && !bus.out_ready) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb_mem_wb_elastic: directed self-checking bench for mem_wb_elastic.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_mem_wb_elastic;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int SW = 32;

  logic clk;
  logic reset;
  logic flush;
  logic [1:0] dbg_state;
`ifdef MEM_WB_STATS_EN
  logic [SW-1:0] stat_retired;
  logic [SW-1:0] stat_stall;
`endif

  int checks;
  int errors;

  mem_wb_if #(.DATA_WIDTH(DW), .REGADDR_WIDTH(RW)) bus ();

  mem_wb_elastic #(
    .DATA_WIDTH(DW),
    .REGADDR_WIDTH(RW),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef MEM_WB_STATS_EN
    ,
    .stat_retired(stat_retired),
    .stat_stall(stat_stall)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic v, input logic rw, input logic mr,
                       input logic [DW-1:0] rdata, input logic [DW-1:0] alu,
                       input logic [RW-1:0] rd);
    bus.in_valid       = v;
    bus.mem_reg_write  = rw;
    bus.mem_mem_read   = mr;
    bus.mem_read_data  = rdata;
    bus.mem_alu_result = alu;
    bus.mem_rd         = rd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the streamed / backpressured entries (wb_rd order)
  logic [RW-1:0] exp_q[$];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_write_data", bus.wb_write_data, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    tick();
    settle();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Back-to-back stream of 4 entries with out_ready=1
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 1'b1, 1'b0, 16'h0, 16'(i * 16'h11), 3'(i));
      exp_q.push_back(3'(i));
      settle();
      chk("stream_in_ready", bus.in_ready, 1);
      if (i > 1) begin
        chk("stream_out_valid", bus.out_valid, 1);
        chk("stream_wb_rd", bus.wb_rd, exp_q.pop_front());
        chk("stream_write_data", bus.wb_write_data, (i - 1) * 16'h11);
        chk("stream_rf_we", bus.wb_rf_we, 1);
      end else begin
        chk("stream_first_empty", bus.out_valid, 0);
      end
      tick();
    end
    offer(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("stream_last_rd", bus.wb_rd, exp_q.pop_front());
    chk("stream_last_data", bus.wb_write_data, 16'h0044);
    chk("stream_last_rf_we", bus.wb_rf_we, 1);
    tick();
    settle();
    chk("stream_drained", bus.out_valid, 0);
    // Stale reg_write in an empty main must not produce a write enable
    chk("stale_reg_write_held", bus.wb_reg_write, 1);
    chk("stale_rf_we", bus.wb_rf_we, 0);

    // Load entry selects read data
    offer(1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 3'd5);
    tick();
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    bus.out_ready = 1'b0;
    settle();
    chk("load_out_valid", bus.out_valid, 1);
    chk("load_write_data", bus.wb_write_data, 16'hBEEF);
    chk("load_mem_to_reg", bus.wb_mem_to_reg, 1);
    chk("load_alu_seen", bus.wb_alu_result, 16'h1234);
    chk("load_rf_we_stalled", bus.wb_rf_we, 0);
    bus.out_ready = 1'b1;
    settle();
    chk("load_rf_we", bus.wb_rf_we, 1);
    tick();

    // Backpressure: A, B fill the buffer, C is held off
    bus.out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h00A0, 3'd2);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h00B0, 3'd3);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h00C0, 3'd4);
    settle();
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_state_full", dbg_state, 2);
    chk("bp_head_a", bus.wb_rd, 2);
    tick();
    settle();
    chk("bp_still_a", bus.wb_rd, 2);
    chk("bp_c_held", bus.in_ready, 0);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    bus.out_ready = 1'b1;
    settle();
    chk("bp_pop_a_we", bus.wb_rf_we, 1);
    chk("bp_pop_a_rd", bus.wb_rd, exp_q.pop_front());
    tick();
    settle();
    chk("bp_b_rd", bus.wb_rd, exp_q.pop_front());
    chk("bp_b_data", bus.wb_write_data, 16'h00B0);
    chk("bp_ready_again", bus.in_ready, 1);
    tick();
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("bp_c_rd", bus.wb_rd, exp_q.pop_front());
    chk("bp_c_data", bus.wb_write_data, 16'h00C0);
    tick();
    settle();
    chk("bp_drained", bus.out_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Flush in FULL with an entry offered
    bus.out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0066, 3'd6);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0077, 3'd7);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h00FF, 3'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("flush_full_out_valid", bus.out_valid, 0);
    chk("flush_full_in_ready", bus.in_ready, 1);
    tick();
    settle();
    chk("flush_full_stays_empty", bus.out_valid, 0);

    // Flush in ONE: pop completes, the simultaneously accepted entry is dropped
    bus.out_ready = 1'b1;
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0011, 3'd1);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0022, 3'd2);
    flush = 1'b1;
    settle();
    chk("flush_pop_rf_we", bus.wb_rf_we, 1);
    chk("flush_pop_rd", bus.wb_rd, 1);
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("flush_one_out_valid", bus.out_valid, 0);
    chk("flush_one_in_ready", bus.in_ready, 1);
    chk("flush_one_rf_we", bus.wb_rf_we, 0);

    // Reset while FULL with out_ready=0
    bus.out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b1, 16'h5555, 16'h0033, 3'd3);
    tick();
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0044, 3'd4);
    tick();
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("pre_rst_full", dbg_state, 2);
    reset = 1'b0;
    tick();
    settle();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_wb_rd", bus.wb_rd, 0);
    chk("midrst_write_data", bus.wb_write_data, 0);
    chk("midrst_read_data", bus.wb_read_data, 0);
    chk("midrst_reg_write", bus.wb_reg_write, 0);
    chk("midrst_mem_to_reg", bus.wb_mem_to_reg, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    settle();
    chk("midrst_release_ready", bus.in_ready, 1);
    chk("midrst_release_empty", bus.out_valid, 0);

`ifdef MEM_WB_STATS_EN
    // Statistics: 3 stall cycles then 5 pops; flush leaves counters alone
    chk("stat_rst_retired", stat_retired, 0);
    chk("stat_rst_stall", stat_stall, 0);
    bus.out_ready = 1'b0;
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0001, 3'd1);
    tick();
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    tick();
    tick();
    tick();
    settle();
    chk("stat_stall_3", stat_stall, 3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(i < 4, 1'b1, 1'b0, 16'h0, 16'(i + 2), 3'(i + 2));
      tick();
    end
    settle();
    chk("stat_retired_5", stat_retired, 5);
    chk("stat_stall_still_3", stat_stall, 3);
    offer(1'b1, 1'b1, 1'b0, 16'h0, 16'h0009, 3'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    settle();
    chk("stat_flush_retired", stat_retired, 5);
    chk("stat_flush_stall", stat_stall, 3);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time bound so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_elastic.md
Name: mem_wb_elastic

Overview:
- Next-generation MEM/WB pipeline register: parametrised width, valid/ready handshake, 2-entry skid buffer, flush.
- Sits between the MEM stage (data memory / ALU result) and the WB stage (register file write port).
- Lets WB stall MEM without a combinational ready path and without losing data.
- Also produces the final muxed writeback value and a single-cycle register-file write enable.

Parameters:
- DATA_WIDTH, 16, width of read data, ALU result and writeback value
- REGADDR_WIDTH, 3, destination register index width
- STAT_WIDTH, 32, width of the statistics counters (used only with MEM_WB_STATS_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous reset, active-low (reset==0 resets on the next rising clk)
- flush  in  1  discard all held entries (branch/exception squash)
- in_valid  in  1  MEM presents a valid entry
- in_ready  out  1  block can accept an entry; registered output
- mem_reg_write  in  1  entry writes the register file
- mem_mem_read  in  1  entry is a load (selects read data for writeback)
- mem_read_data  in  DATA_WIDTH  data memory read value
- mem_alu_result  in  DATA_WIDTH  ALU result
- mem_rd  in  REGADDR_WIDTH  destination register
- out_valid  out  1  head entry valid toward WB
- out_ready  in  1  WB consumes the head entry this cycle
- wb_reg_write  out  1  head entry reg_write
- wb_mem_to_reg  out  1  head entry mem_read
- wb_read_data  out  DATA_WIDTH  head entry read data
- wb_alu_result  out  DATA_WIDTH  head entry ALU result
- wb_rd  out  REGADDR_WIDTH  head entry destination
- wb_write_data  out  DATA_WIDTH  wb_mem_to_reg ? wb_read_data : wb_alu_result (combinational from head)
- wb_rf_we  out  1  out_valid & out_ready & wb_reg_write (combinational)

Behaviour:
- Storage: main register (head, drives wb_* outputs) and skid register; each has its own valid bit.
- States:
  - EMPTY: no valid entries.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- Handshake signals:
  - in_ready = (state != FULL), registered.
  - out_valid = main valid.
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
- Transitions, when flush==0:
  - EMPTY, accept -> ONE; input loads main.
  - ONE, accept & pop -> ONE; input loads main.
  - ONE, accept & !pop -> FULL; input loads skid.
  - ONE, !accept & pop -> EMPTY.
  - FULL, pop -> ONE; skid moves to main. in_ready was 0, so no accept is possible.
  - Any other combination: hold.
- Ordering: strictly FIFO, no reordering, no duplication.
- Latency: an entry accepted in cycle N is visible on wb_* with out_valid=1 in cycle N+1 when the block was EMPTY or popping.
- Throughput: 1 entry/cycle when out_ready stays high.
- Flush:
  - Both valid bits clear on the next edge; state becomes EMPTY; in_ready=1 the following cycle.
  - Flush wins over a simultaneous accept: the incoming entry is dropped.
  - A pop in the flush cycle still completes; wb_rf_we is asserted that cycle if otherwise valid.
- Payload registers load only on accept or skid-move; otherwise they hold. Payload value is don't-care while its valid bit is 0.
- Reset (reset==0 at a rising edge):
  - All valid bits, payload registers and wb_* outputs go to 0.
  - in_ready=0 during reset cycles, then 1 in the first cycle after reset deasserts.
  - Overrides flush and the handshakes.
  - Reset mid-FULL discards both entries.
- wb_rf_we never asserts while out_valid==0, even if stale wb_reg_write==1.

Optional Feature:
- Macro MEM_WB_STATS_EN.
- Defined:
  - Adds outputs stat_retired (STAT_WIDTH) and stat_stall (STAT_WIDTH).
  - stat_retired increments on each pop.
  - stat_stall increments on each cycle with out_valid & !out_ready.
  - Both wrap modulo 2^STAT_WIDTH, reset to 0 on reset, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then stream 4 entries back-to-back with out_ready=1:
  - Entries: rd=1..4, alu=16'h0011..16'h0044, mem_read=0, reg_write=1.
  - Required: each appears 1 cycle later, in order; wb_write_data equals alu; wb_rf_we=1 on 4 consecutive cycles; in_ready stays 1.
- Load entry, mem_read=1, read_data=16'hBEEF, alu=16'h1234 -> wb_write_data=16'hBEEF, wb_mem_to_reg=1.
- Backpressure:
  - Stimulus: out_ready=0, offer A(rd=2) then B(rd=3) then C(rd=4) with in_valid held.
  - Required: A in main, B in skid, in_ready=0, C held off.
  - Then raise out_ready: A, B, C retire in order; no loss or duplicate.
- Flush in FULL with a simultaneous in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered entry never appears on wb_*.
- Assert reset low while FULL with out_ready=0 -> next cycle all wb_* = 0, out_valid=0; in_ready=1 one cycle after release.
- With MEM_WB_STATS_EN defined: 3 stall cycles then 5 pops -> stat_stall=3, stat_retired=5; a flush leaves both unchanged.
